// File: rtl/spi_mult_sequencer.sv
// spi_mult_sequencer: SPI multiply transaction sequencer (load operands, run multiplier, shift result out).
// Define SPIMULT_TIMEOUT_EN to add a multiplier timeout with sticky timeout_err.
module spi_mult_sequencer #(
    parameter int OP_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk_rise,
    input  logic       sclk_fall,
    input  logic       mult_done,
    output logic [1:0] sr_mode,
    output logic       mult_start,
    output logic       miso_buff_en,
    output logic       xfer_done,
    output logic       timeout_err,
    output logic [2:0] state
);
    localparam int CW = $clog2(2*OP_WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(2*OP_WIDTH-1);
    localparam logic [1:0] HOLD = 2'd0, LEFT = 2'd1, PLOAD = 2'd2;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_MULT = 3'd2, S_CAPTURE = 3'd3, S_SHIFTOUT = 3'd4;

    logic [2:0]    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          w_shift_in, w_shift_out, w_first, w_done, w_tout;

    // cs low wins over any strobe in the same clk
    assign w_shift_in  = r_state == S_LOAD && cs && sclk_rise;
    assign w_shift_out = r_state == S_SHIFTOUT && cs && sclk_fall;
    assign w_first     = r_state == S_MULT && r_cnt == '0;
    assign w_done      = r_state == S_MULT && !w_first && mult_done;

`ifdef SPIMULT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    logic [TW-1:0] r_tcnt;
    logic          r_terr;
    assign w_tout      = r_state == S_MULT && !w_done && r_tcnt == TW'(TIMEOUT_CYCLES-1);
    assign timeout_err = r_terr;
    always_ff @(posedge clk) begin
        r_tcnt <= (reset || r_state != S_MULT) ? '0 : r_tcnt + TW'(1);
        r_terr <= reset ? 1'b0 : w_tout ? 1'b1 : (r_state == S_IDLE && cs) ? 1'b0 : r_terr;
    end
`else
    assign w_tout      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(w_shift_in || w_shift_out || w_first);
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = cs ? S_LOAD : S_IDLE;
            S_LOAD:     w_next = !cs ? S_IDLE : (w_shift_in && r_cnt == LAST) ? S_MULT : S_LOAD;
            S_MULT:     w_next = w_done ? S_CAPTURE : w_tout ? S_IDLE : S_MULT;
            S_CAPTURE:  w_next = S_SHIFTOUT;
            S_SHIFTOUT: w_next = (!cs || (w_shift_out && r_cnt == LAST)) ? S_IDLE : S_SHIFTOUT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sr_mode      = (w_shift_in || w_shift_out) ? LEFT : (r_state == S_CAPTURE) ? PLOAD : HOLD;
        mult_start   = w_first;
        miso_buff_en = r_state == S_LOAD || r_state == S_SHIFTOUT;
        xfer_done    = w_shift_out && r_cnt == LAST;
        state        = r_state;
    end
endmodule

// File: doc/spi_mult_sequencer.md
SPI_MULT_SEQUENCER -- requirements
Module: spi_mult_sequencer

Interface
REQ-001 The block SHALL have parameter OP_WIDTH, default 8, giving the bits per operand; legal range is 2..32.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the clk cycles allowed for the multiplier; it is used only with SPIMULT_TIMEOUT_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cs, input, 1 bit: chip select, active-high, already synchronised to clk.
REQ-006 The block SHALL have port sclk_rise, input, 1 bit: one-clk strobe marking an SPI clock rising edge.
REQ-007 The block SHALL have port sclk_fall, input, 1 bit: one-clk strobe marking an SPI clock falling edge.
REQ-008 The block SHALL have port mult_done, input, 1 bit: multiplier completion; a pulse or a level is accepted.
REQ-009 The block SHALL have port sr_mode, output, 2 bits: shift-register command using the shared HOLD/LEFT/PLOAD encodings.
REQ-010 The block SHALL have port mult_start, output, 1 bit: one-clk start pulse to the multiplier.
REQ-011 The block SHALL have port miso_buff_en, output, 1 bit: MISO output-buffer enable.
REQ-012 The block SHALL have port xfer_done, output, 1 bit: one-clk pulse when a result has been fully shifted out.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky error flag.
REQ-014 The block SHALL have port state, output, 3 bits: current state, for debug.

Function
REQ-015 The block SHALL implement states IDLE=0, LOAD=1, MULT=2, CAPTURE=3 and SHIFTOUT=4; codes 5-7 SHALL return to IDLE on the next clk.
REQ-016 The block SHALL hold a bit counter of width $clog2(2*OP_WIDTH+1), cleared on every state entry.
REQ-017 In IDLE, cs=1 SHALL cause a move to LOAD on the next clk and SHALL clear timeout_err.
REQ-018 In LOAD, each sclk_rise SHALL give sr_mode=LEFT for exactly that clk and increment the counter; at all other times sr_mode SHALL be HOLD.
REQ-019 After the 2*OP_WIDTH-th sclk_rise, the block SHALL enter MULT on the following clk; sclk_rise strobes arriving after that point SHALL be ignored.
REQ-020 On entry to MULT, the block SHALL drive mult_start=1 for exactly the first MULT clk, with sr_mode=HOLD throughout MULT.
REQ-021 mult_done SHALL be sampled only from the second MULT clk onward; mult_done high in the same clk as mult_start SHALL be ignored.
REQ-022 mult_done=1 in MULT SHALL cause entry to CAPTURE on the next clk.
REQ-023 CAPTURE SHALL last exactly one clk, with sr_mode=PLOAD, and SHALL then go to SHIFTOUT.
REQ-024 In SHIFTOUT, each sclk_fall SHALL give sr_mode=LEFT for that clk and increment the counter.
REQ-025 After the 2*OP_WIDTH-th sclk_fall in SHIFTOUT, the block SHALL pulse xfer_done for one clk and return to IDLE.
REQ-026 miso_buff_en SHALL be 1 in LOAD and SHIFTOUT and 0 in all other states.
REQ-027 cs=0 in LOAD or SHIFTOUT SHALL abort to IDLE on the next clk with no shift in that clk; cs deassertion SHALL take priority over a simultaneous strobe; no xfer_done pulse SHALL be produced on abort.
REQ-028 cs SHALL be ignored in MULT and CAPTURE; if cs=0 on SHIFTOUT entry, REQ-027 SHALL apply.
REQ-029 In IDLE, a transaction SHALL start only on cs=1; cs held high after xfer_done SHALL start a new transaction (back-to-back operation).

Reset
REQ-030 reset=1 at posedge clk SHALL force IDLE, counter=0, sr_mode=HOLD, mult_start=0, miso_buff_en=0, xfer_done=0 and timeout_err=0, overriding all other inputs in that cycle.
REQ-031 reset asserted mid-transaction SHALL abandon that transaction with no xfer_done or timeout_err; mult_done arriving after reset SHALL be ignored.

Configuration
REQ-032 With SPIMULT_TIMEOUT_EN defined, a cycle counter SHALL run in MULT; if mult_done has not arrived after TIMEOUT_CYCLES clks, the block SHALL go to IDLE and set timeout_err=1.
REQ-033 A timeout SHALL NOT produce a CAPTURE or SHIFTOUT, and timeout_err SHALL hold until reset or the next cs=1 in IDLE.
REQ-034 Without SPIMULT_TIMEOUT_EN, MULT SHALL wait indefinitely for mult_done, timeout_err SHALL be constant 0, and no timeout counter logic SHALL be synthesised.

Verification
REQ-035 OP_WIDTH=8, cs=1, 16 sclk_rise strobes -> 16 single-clk LEFT commands, MULT entered, mult_start high for exactly 1 clk.
REQ-036 mult_done after 5 clks -> CAPTURE with PLOAD for 1 clk, then 16 sclk_fall strobes -> 16 LEFT commands, one xfer_done pulse, state=0.
REQ-037 cs dropped after 7 sclk_rise strobes, with an 8th strobe in the same clk -> no shift in that clk, IDLE next clk, xfer_done stays 0.
REQ-038 mult_done held high during the mult_start clk, then low -> the block remains in MULT.
REQ-039 With SPIMULT_TIMEOUT_EN and TIMEOUT_CYCLES=4, no mult_done -> IDLE after 4 MULT clks, timeout_err=1; the next cs=1 clears it.
REQ-040 reset pulsed in SHIFTOUT after 3 sclk_fall strobes -> all outputs at reset values next clk, and a following full transaction completes normally.
